// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between the in-order
// writeback stage (port 0) and a long-latency unit (port 1). Port 0 has fixed
// priority. Port 1 gets a forced grant after MAX_WAIT consecutive denials.
// A per-register busy scoreboard tracks results still owed by port 1, and it
// holds back port-0 writes that would otherwise overtake them (WAW ordering).
`timescale 1ns/1ps

module regfile_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4,
    localparam int NUM_WORDS = 2**ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  p0_valid_i,
    output logic                  p0_ready_o,
    input  logic [ADDR_WIDTH-1:0] p0_addr_i,
    input  logic [DATA_WIDTH-1:0] p0_data_i,
    input  logic                  p1_valid_i,
    output logic                  p1_ready_o,
    input  logic [ADDR_WIDTH-1:0] p1_addr_i,
    input  logic [DATA_WIDTH-1:0] p1_data_i,
    input  logic                  issue_i,
    input  logic [ADDR_WIDTH-1:0] issue_addr_i,
    output logic [NUM_WORDS-1:0]  busy_o,
    output logic [ADDR_WIDTH-1:0] waddr_a_o,
    output logic [DATA_WIDTH-1:0] wdata_a_o,
    output logic                  we_a_o
);

    // The counter only needs to hold values from 0 to MAX_WAIT.
    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    typedef enum logic {
        ST_NORMAL,
        ST_FORCE
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     wait_q, wait_d;
    logic [NUM_WORDS-1:0] busy_q, busy_d;

    logic p0_blocked;
    logic p0_grant;
    logic p1_grant;

    // Grant selection. This is combinational so that a write completes in the same cycle it is requested.
    always_comb begin
        p0_blocked = p0_valid_i && (p0_addr_i != '0) && busy_q[p0_addr_i];
        p0_grant   = 1'b0;
        p1_grant   = 1'b0;
        if (!rst_i) begin
            if (state_q == ST_FORCE) begin
                p1_grant = p1_valid_i;
            end else if (p0_valid_i && !p0_blocked) begin
                p0_grant = 1'b1;
            end else begin
                p1_grant = p1_valid_i;
            end
        end
    end

    // Starvation tracking: count consecutive port-1 denials and force a grant once MAX_WAIT is reached.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_NORMAL: begin
                if (p1_valid_i && !p1_grant) begin
                    wait_d = wait_q + CNT_W'(1);
                    if (wait_d == MAX_CNT) begin
                        state_d = ST_FORCE;
                    end
                end else begin
                    wait_d = '0;
                end
            end
            ST_FORCE: begin
                // In this state port 1 either transfers or withdraws its request. Both cases return to NORMAL.
                wait_d  = '0;
                state_d = ST_NORMAL;
            end
            default: begin
                wait_d  = '0;
                state_d = ST_NORMAL;
            end
        endcase
    end

    // Scoreboard update. A new issue takes precedence over a same-cycle port-1 retirement. Register 0 is never tracked.
    always_comb begin
        busy_d = busy_q;
        if (p1_grant && (p1_addr_i != '0)) begin
            busy_d[p1_addr_i] = 1'b0;
        end
        if (issue_i && (issue_addr_i != '0)) begin
            busy_d[issue_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Write-port mux. Source follows the granted port. Writes to register 0 complete but are suppressed.
    always_comb begin
        if (p1_grant) begin
            waddr_a_o = p1_addr_i;
            wdata_a_o = p1_data_i;
        end else begin
            waddr_a_o = p0_addr_i;
            wdata_a_o = p0_data_i;
        end
        we_a_o = (p0_grant && (p0_addr_i != '0)) || (p1_grant && (p1_addr_i != '0));
    end

    // State, wait counter and scoreboard registers. Reset discards all pending entries.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_NORMAL;
            wait_q  <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            busy_q  <= busy_d;
        end
    end

    assign p0_ready_o = p0_grant;
    assign p1_ready_o = p1_grant;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scoreboard bench for the writeback arbiter.
// The driver issues stimulus and pushes per-cycle expectations that come from
// a behavioural model. A monitor on the falling edge pops the expectations and
// compares them against the DUT outputs.
`timescale 1ns/1ps

module tb_regfile_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int NW = 2**AW;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          p0_valid_i, p0_ready_o;
    logic [AW-1:0] p0_addr_i;
    logic [DW-1:0] p0_data_i;
    logic          p1_valid_i, p1_ready_o;
    logic [AW-1:0] p1_addr_i;
    logic [DW-1:0] p1_data_i;
    logic          issue_i;
    logic [AW-1:0] issue_addr_i;
    logic [NW-1:0] busy_o;
    logic [AW-1:0] waddr_a_o;
    logic [DW-1:0] wdata_a_o;
    logic          we_a_o;

    regfile_wb_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_WAIT  (MW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .p0_valid_i  (p0_valid_i),
        .p0_ready_o  (p0_ready_o),
        .p0_addr_i   (p0_addr_i),
        .p0_data_i   (p0_data_i),
        .p1_valid_i  (p1_valid_i),
        .p1_ready_o  (p1_ready_o),
        .p1_addr_i   (p1_addr_i),
        .p1_data_i   (p1_data_i),
        .issue_i     (issue_i),
        .issue_addr_i(issue_addr_i),
        .busy_o      (busy_o),
        .waddr_a_o   (waddr_a_o),
        .wdata_a_o   (wdata_a_o),
        .we_a_o      (we_a_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          p0r;
        logic          p1r;
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [NW-1:0] busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   fails  = 0;

    // Reference model state: the set of registers still owed by port 1, and how long port 1 has been refused in a row.
    logic [NW-1:0] mdl_busy   = '0;
    int            mdl_streak = 0;
    logic          last_g0    = 1'b0;
    logic          last_g1    = 1'b0;

    // Random-stimulus request registers. A held request keeps its address and data.
    logic          r_v0 = 1'b0, r_v1 = 1'b0, r_iss;
    logic [AW-1:0] r_a0 = '0, r_a1 = '0, r_ia;
    logic [DW-1:0] r_d0 = '0, r_d1 = '0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Drive one cycle of inputs, predict this cycle's outputs from the model, then advance the model past the clock edge.
    task automatic applyStimulus(input logic rst,
                                 input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                 input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                 input logic iss, input logic [AW-1:0] ia);
        exp_t e;
        logic forced, blk, g0, g1;
        @(posedge clk_i);
        #1;
        rst_i        = rst;
        p0_valid_i   = v0;
        p0_addr_i    = a0;
        p0_data_i    = d0;
        p1_valid_i   = v1;
        p1_addr_i    = a1;
        p1_data_i    = d1;
        issue_i      = iss;
        issue_addr_i = ia;
        e = '{default: '0};
        g0 = 1'b0;
        g1 = 1'b0;
        if (rst) begin
            mdl_busy   = '0;
            mdl_streak = 0;
            exp_q.push_back(e);
        end else begin
            forced = (mdl_streak >= MW);
            blk    = v0 && (a0 != 0) && mdl_busy[a0];
            g0     = !forced && v0 && !blk;
            g1     = v1 && !g0;
            e.p0r   = g0;
            e.p1r   = g1;
            e.we    = (g0 && a0 != 0) || (g1 && a1 != 0);
            e.waddr = g1 ? a1 : a0;
            e.wdata = g1 ? d1 : d0;
            e.busy  = mdl_busy;
            exp_q.push_back(e);
            assert (!(iss && ia != 0 && mdl_busy[ia])) else $error("[TB] stimulus issued to a register that is already busy");
            if (g1 && a1 != 0) mdl_busy[a1] = 1'b0;
            if (iss && ia != 0) mdl_busy[ia] = 1'b1;
            mdl_streak = (v1 && !g1) ? mdl_streak + 1 : 0;
        end
        last_g0 = g0;
        last_g1 = g1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    // Assert reset asynchronously, away from any clock edge. The outputs must clear immediately.
    task automatic midReset();
        @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("async_rst_busy", 64'(busy_o), 64'd0);
        checkOutput("async_rst_p0_ready", 64'(p0_ready_o), 64'd0);
        checkOutput("async_rst_p1_ready", 64'(p1_ready_o), 64'd0);
        checkOutput("async_rst_we", 64'(we_a_o), 64'd0);
        mdl_busy   = '0;
        mdl_streak = 0;
    endtask

    function automatic logic [AW-1:0] pickBusy();
        int s = $urandom_range(0, NW-1);
        for (int k = 0; k < NW; k++) begin
            if (mdl_busy[(s + k) % NW]) return AW'((s + k) % NW);
        end
        return AW'($urandom_range(0, NW-1));
    endfunction

    // Monitor: on every falling edge, compare the DUT against the oldest pending expectation.
    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checkOutput("p0_ready", 64'(p0_ready_o), 64'(mon_e.p0r));
            checkOutput("p1_ready", 64'(p1_ready_o), 64'(mon_e.p1r));
            checkOutput("we", 64'(we_a_o), 64'(mon_e.we));
            checkOutput("busy", 64'(busy_o), 64'(mon_e.busy));
            if (mon_e.we) begin
                checkOutput("waddr", 64'(waddr_a_o), 64'(mon_e.waddr));
                checkOutput("wdata", 64'(wdata_a_o), 64'(mon_e.wdata));
            end
        end
    end

    initial begin
        rst_i = 1'b1; p0_valid_i = 1'b0; p0_addr_i = '0; p0_data_i = '0;
        p1_valid_i = 1'b0; p1_addr_i = '0; p1_data_i = '0; issue_i = 1'b0; issue_addr_i = '0;

        // Reset held with requests pending: no grants, no writes, empty scoreboard.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 5'd2, 32'h11, 1'b1, 5'd6, 32'h22, 1'b1, 5'd3);
        idle(2);
        applyStimulus(1'b0, 1'b1, 5'd1, 32'hCAFE, 1'b0, '0, '0, 1'b0, '0);
        idle(1);

        // Priority with forced grant: p0 wins cycles 0-3, p1 is forced in cycle 4, and p0 wins again in cycle 5.
        for (int c = 0; c < 6; c++)
            applyStimulus(1'b0, 1'b1, 5'd3, 32'hAAAA, (c <= 4), 5'd7, 32'h5555, 1'b0, '0);
        idle(1);

        // WAW guard: issue x9, p0 to x9 stalls, p1 retires x9, and p0 is granted the following cycle.
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9);
        applyStimulus(1'b0, 1'b1, 5'd9, 32'hBEEF, 1'b0, '0, '0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 5'd9, 32'hBEEF, 1'b1, 5'd9, 32'h1234, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 5'd9, 32'hBEEF, 1'b0, '0, '0, 1'b0, '0);
        idle(1);

        // Same-cycle issue and retirement of x12: the new owner keeps the bit set.
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 5'd12, 32'h4321, 1'b1, 5'd12);
        idle(1);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 5'd12, 32'h9876, 1'b0, '0);
        idle(1);

        // Register 0: the transfer completes without a write, and an issue to x0 is ignored.
        applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFF, 1'b0, '0, '0, 1'b1, 5'd0);
        idle(1);

        // p1 withdraws after two denials: the count restarts, and a full MAX_WAIT denials are needed again.
        for (int c = 0; c < 9; c++)
            applyStimulus(1'b0, 1'b1, 5'd4, 32'h4000 + 32'(c), (c != 2 && c != 8), 5'd8, 32'h8888, 1'b0, '0);
        idle(1);

        // Reset in the middle of a forced cycle while x5 is busy.
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd5);
        for (int c = 0; c < 5; c++)
            applyStimulus(1'b0, 1'b1, 5'd3, 32'hA0 + 32'(c), 1'b1, 5'd7, 32'h70, 1'b0, '0);
        midReset();
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
        idle(2);

        // Random traffic. Requests are held until granted, with an occasional withdrawal.
        for (int i = 0; i < 2000; i++) begin
            if (r_v0 && !last_g0) begin
                if ($urandom_range(0, 7) == 0) r_v0 = 1'b0;
            end else begin
                r_v0 = ($urandom_range(0, 3) != 0);
                r_a0 = AW'($urandom_range(0, NW-1));
                r_d0 = DW'($urandom);
            end
            if (r_v1 && !last_g1) begin
                if ($urandom_range(0, 7) == 0) r_v1 = 1'b0;
            end else begin
                r_v1 = ($urandom_range(0, 2) == 0);
                r_a1 = ($urandom_range(0, 3) != 0) ? pickBusy() : AW'($urandom_range(0, NW-1));
                r_d1 = DW'($urandom);
            end
            r_ia  = AW'($urandom_range(0, NW-1));
            r_iss = ($urandom_range(0, 3) == 0) && !mdl_busy[r_ia];
            applyStimulus(1'b0, r_v0, r_a0, r_d0, r_v1, r_a1, r_d1, r_iss, r_ia);
        end
        idle(2);

        @(negedge clk_i);
        #1;
        checkOutput("drain", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources:
  - port 0: in-order pipeline WB stage.
  - port 1: long-latency unit (LSU / mul-div).
- Fixed priority to port 0, with a starvation limit that forces a port-1 grant.
- Holds a per-register busy scoreboard for results owed by port 1. Decode stalls on busy_o and port-0 WAW ordering is enforced.
- Sits between the writeback sources and the register file write port; drives waddr/wdata/we directly.

Parameters:
- ADDR_WIDTH, 5, register address width; NUM_WORDS = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register data width.
- MAX_WAIT, 4, consecutive cycles port 1 may be denied before a forced grant (>=1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- p0_valid_i  in  1  pipeline WB write request.
- p0_ready_o  out  1  port 0 granted this cycle.
- p0_addr_i  in  ADDR_WIDTH  port 0 destination register.
- p0_data_i  in  DATA_WIDTH  port 0 write data.
- p1_valid_i  in  1  long-latency unit write request.
- p1_ready_o  out  1  port 1 granted this cycle.
- p1_addr_i  in  ADDR_WIDTH  port 1 destination register.
- p1_data_i  in  DATA_WIDTH  port 1 write data.
- issue_i  in  1  long-latency op issued; mark destination busy.
- issue_addr_i  in  ADDR_WIDTH  destination of issued op.
- busy_o  out  NUM_WORDS  scoreboard bitmap; bit 0 always 0.
- waddr_a_o  out  ADDR_WIDTH  regfile write address.
- wdata_a_o  out  DATA_WIDTH  regfile write data.
- we_a_o  out  1  regfile write enable.

Behaviour:
- Reset (rst_i=1, async):
  - busy_o=0, wait counter=0, state=NORMAL.
  - p0_ready_o=0, p1_ready_o=0, we_a_o=0 while reset is held.
  - Reset mid-operation discards all pending scoreboard entries.
- Handshake and latency:
  - A transfer occurs when valid && ready in the same cycle.
  - Grant is combinational; the regfile write happens at that cycle's rising edge, so latency is 0 cycles.
  - valid may not depend on ready. Address/data must be held stable while valid && !ready.
- Write-port mux:
  - we_a_o = transfer on either port && granted addr != 0.
  - waddr_a_o / wdata_a_o come from the granted port. With no grant they are don't-care; drive from port 0.
  - Address-0 transfers complete (ready=1) but we_a_o=0.
- At most one grant per cycle.
- p0_blocked = p0_valid_i && p0_addr_i != 0 && busy[p0_addr_i] (WAW guard).
- State machine:
  - NORMAL:
    - Grant p0 if p0_valid_i && !p0_blocked; otherwise grant p1 if p1_valid_i.
    - Counter: increments when p1_valid_i && !p1 granted; clears on p1 grant or !p1_valid_i.
    - When the counter reaches MAX_WAIT and p1_valid_i is still denied, go to FORCE.
  - FORCE:
    - p1_ready_o = p1_valid_i, p0_ready_o=0.
    - On p1 transfer: counter=0, go to NORMAL.
    - If p1_valid_i drops: go to NORMAL, counter=0.
- Scoreboard (per register r != 0, updated at the clock edge):
  - Set when issue_i && issue_addr_i==r.
  - Clear when a p1 transfer writes r.
  - Set and clear of the same r in one cycle: set wins (new owner).
  - issue_i to an already-busy register: illegal; the bit stays 1 (assertion in the bench).
  - issue_addr_i==0: ignored.
  - A p1 transfer to a non-busy register still writes; no scoreboard change.
- busy_o is registered; the clear is visible the cycle after the p1 write. A p0 request blocked on that register is granted that following cycle.
- Deadlock freedom: p1 is never blocked by the scoreboard, so a blocked p0 always makes progress once p1 delivers.

Test Plan:
- Reset then idle -> busy_o=0, we_a_o=0, both readies 0 during reset and ready=valid-gated afterwards. Assert rst_i mid-FORCE with busy[5]=1 -> immediate busy_o=0, state NORMAL.
- p0 and p1 both valid with distinct addrs (p0 x3=0xAAAA, p1 x7=0x5555), MAX_WAIT=4:
  - p0 is granted cycles 0-3.
  - Cycle 4: FORCE, p1_ready_o=1, p0_ready_o=0, we_a_o=1, waddr_a_o=7.
  - Cycle 5: p0 granted again.
- issue_i addr=9 -> busy_o[9]=1 next cycle; p0 valid to x9 -> p0_ready_o=0. p1 writes x9=0x1234 -> busy_o[9]=0 next cycle and p0 is granted that cycle.
- Same-cycle issue_i addr=12 and p1 transfer to x12 -> busy_o[12] remains 1.
- p0 transfer to x0 with data 0xFFFF -> p0_ready_o=1, we_a_o=0; issue_i addr=0 -> busy_o[0] stays 0.
- p1_valid_i drops after 2 denied cycles -> counter clears; p1 re-asserts and needs a full MAX_WAIT denials before FORCE.
